// File: rtl/regfile_mp.sv
// Multi-port integer register file with registered reads, same-cycle write
// forwarding and a per-register busy scoreboard for pending writebacks.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_addr_in,
    output logic [NRD*XLEN-1:0] rs_data_out,
    output logic [NRD-1:0]      rs_busy_out,
    input  logic [NWR-1:0]      rd_we_in,
    input  logic [NWR*AW-1:0]   rd_addr_in,
    input  logic [NWR*XLEN-1:0] rd_data_in,
    input  logic                rsv_we_in,
    input  logic [AW-1:0]       rsv_addr_in,
    output logic [NREGS-1:0]    busy_vec_out
);

    logic [XLEN-1:0]  regs     [NREGS];
    logic [XLEN-1:0]  reg_nxt  [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Post-edge view of the file: ascending port order lets the highest
    // index win a collision; a reserve outranks a same-cycle writeback.
    always_comb begin
        for (int r = 0; r < int'(NREGS); r++) begin
            reg_nxt[r] = regs[r];
        end
        busy_nxt = busy;
        for (int j = 0; j < int'(NWR); j++) begin
            if (rd_we_in[j]) begin
                reg_nxt[rd_addr_in[j*AW +: AW]]  = rd_data_in[j*XLEN +: XLEN];
                busy_nxt[rd_addr_in[j*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_we_in) begin
            busy_nxt[rsv_addr_in] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            reg_nxt[0]  = '0;
            busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs[r] <= reg_nxt[r];
            end
            busy <= busy_nxt;
        end
    end

    // Read ports sample the post-edge view so data and busy stay coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_data_out <= '0;
            rs_busy_out <= '0;
        end else begin
            for (int i = 0; i < int'(NRD); i++) begin
                rs_data_out[i*XLEN +: XLEN] <= reg_nxt[rs_addr_in[i*AW +: AW]];
                rs_busy_out[i]              <= busy_nxt[rs_addr_in[i*AW +: AW]];
            end
        end
    end

    assign busy_vec_out = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, forwarding, collisions, scoreboard,
// zero register and asynchronous reset.
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rs_addr_in;
    logic [NRD*XLEN-1:0] rs_data_out;
    logic [NRD-1:0]      rs_busy_out;
    logic [NWR-1:0]      rd_we_in;
    logic [NWR*AW-1:0]   rd_addr_in;
    logic [NWR*XLEN-1:0] rd_data_in;
    logic                rsv_we_in;
    logic [AW-1:0]       rsv_addr_in;
    logic [NREGS-1:0]    busy_vec_out;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst),
        .rs_addr_in(rs_addr_in), .rs_data_out(rs_data_out), .rs_busy_out(rs_busy_out),
        .rd_we_in(rd_we_in), .rd_addr_in(rd_addr_in), .rd_data_in(rd_data_in),
        .rsv_we_in(rsv_we_in), .rsv_addr_in(rsv_addr_in), .busy_vec_out(busy_vec_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_port(input int p, input logic [AW-1:0] a);
        rs_addr_in[p*AW +: AW] = a;
    endtask

    task automatic wr_port(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        rd_we_in[p]              = 1'b1;
        rd_addr_in[p*AW +: AW]   = a;
        rd_data_in[p*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        rd_we_in  = '0;
        rsv_we_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rs_addr_in = '0; rd_we_in = '0; rd_addr_in = '0; rd_data_in = '0;
        rsv_we_in = 1'b0; rsv_addr_in = '0;
        #2;
        check("reset_busy_vec", busy_vec_out, 32'h0);
        check("reset_data", rs_data_out[31:0], 32'h0);
        rst = 1'b0;

        // Sweep all addresses on both ports after reset
        for (int a = 0; a < int'(NREGS); a++) begin
            rd_port(0, AW'(a));
            rd_port(1, AW'(NREGS - 1 - a));
            tick();
            check("sweep_d0", rs_data_out[31:0], 32'h0);
            check("sweep_d1", rs_data_out[63:32], 32'h0);
            check("sweep_busy", {30'h0, rs_busy_out}, 32'h0);
        end
        check("sweep_busy_vec", busy_vec_out, 32'h0);

        // Forwarded write, then stored read
        wr_port(0, 5'd5, 32'hDEADBEEF);
        rd_port(0, 5'd5);
        tick();
        check("fwd_x5", rs_data_out[31:0], 32'hDEADBEEF);
        idle();
        tick();
        tick();
        check("stored_x5", rs_data_out[31:0], 32'hDEADBEEF);

        // Two-port collision: port 1 wins
        wr_port(0, 5'd7, 32'h11111111);
        wr_port(1, 5'd7, 32'h22222222);
        rd_port(1, 5'd7);
        tick();
        check("coll_fwd", rs_data_out[63:32], 32'h22222222);
        idle();
        tick();
        check("coll_stored", rs_data_out[63:32], 32'h22222222);
        check("x5_untouched", rs_data_out[31:0], 32'hDEADBEEF);

        // Reserve x9, idle, then write back
        rsv_we_in = 1'b1; rsv_addr_in = 5'd9;
        rd_port(0, 5'd9);
        tick();
        idle();
        tick(); tick(); tick();
        check("rsv_vec9", {31'h0, busy_vec_out[9]}, 32'h1);
        check("rsv_rs_busy", {31'h0, rs_busy_out[0]}, 32'h1);
        wr_port(0, 5'd9, 32'h5);
        tick();
        check("wb_busy", {31'h0, rs_busy_out[0]}, 32'h0);
        check("wb_data", rs_data_out[31:0], 32'h5);
        check("wb_vec", busy_vec_out, 32'h0);
        idle();

        // Reserve and write same address: reserve wins busy, data still written
        wr_port(0, 5'd9, 32'hA);
        rsv_we_in = 1'b1; rsv_addr_in = 5'd9;
        tick();
        check("rsvwr_vec", busy_vec_out, 32'h0000_0200);
        check("rsvwr_busy", {31'h0, rs_busy_out[0]}, 32'h1);
        check("rsvwr_data", rs_data_out[31:0], 32'hA);
        idle();

        // Zero register ignores writes and reserves
        wr_port(1, 5'd0, 32'hFFFFFFFF);
        rsv_we_in = 1'b1; rsv_addr_in = 5'd0;
        rd_port(1, 5'd0);
        tick();
        check("x0_data", rs_data_out[63:32], 32'h0);
        check("x0_busy", {31'h0, rs_busy_out[1]}, 32'h0);
        check("x0_vec", busy_vec_out, 32'h0000_0200);
        idle();
        tick();
        check("x0_stored", rs_data_out[63:32], 32'h0);

        // Asynchronous reset between edges
        wr_port(0, 5'd3, 32'h1234);
        rsv_we_in = 1'b1; rsv_addr_in = 5'd3;
        rd_port(0, 5'd3);
        tick();
        check("pre_rst_data", rs_data_out[31:0], 32'h1234);
        check("pre_rst_busy", {31'h0, rs_busy_out[0]}, 32'h1);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_data", rs_data_out[31:0], 32'h0);
        check("arst_busy", {30'h0, rs_busy_out}, 32'h0);
        check("arst_vec", busy_vec_out, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_x3", rs_data_out[31:0], 32'h0);
        check("post_rst_busy", {31'h0, rs_busy_out[0]}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
